// File: rtl/chess_pkg.sv
// Shared types and constants for the board cursor and move-select logic.
package chess_pkg;

  localparam int COORD_W = 3;

  typedef logic [1:0] state_t;
  localparam state_t PICK_FROM = 2'd0;
  localparam state_t PICK_TO   = 2'd1;
  localparam state_t SEND      = 2'd2;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Default start square: file e, rank 2.
  localparam logic [COORD_W-1:0] DEF_START_X = 3'd4;
  localparam logic [COORD_W-1:0] DEF_START_Y = 3'd1;

endpackage

// File: rtl/cursor_axis.sv
// One board axis: 3-bit position with inc/dec/hold and wrap-or-saturate edges.
module cursor_axis
  import chess_pkg::*;
#(
  parameter bit                 WRAP  = 1'b1,
  parameter logic [COORD_W-1:0] START = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               inc,
  input  logic               dec,
  output logic [COORD_W-1:0] value
);

  localparam logic [COORD_W-1:0] MAX_POS = '1;

  logic [COORD_W-1:0] value_q;
  logic [COORD_W-1:0] value_d;

  // inc and dec together cancel out and leave the axis where it is.
  always_comb begin
    value_d = value_q;
    if (en && inc && !dec) begin
      if (WRAP || value_q != MAX_POS) value_d = value_q + 1'b1;
    end else if (en && dec && !inc) begin
      if (WRAP || value_q != '0) value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= START;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/move_select.sv
// Board cursor plus pick-from / pick-to FSM presenting moves over valid/ready.
// Optional idle abandon in PICK_TO is built only when MOVE_TIMEOUT_EN is defined.
module move_select
  import chess_pkg::*;
#(
  parameter bit                 WRAP          = 1'b1,
  parameter logic [COORD_W-1:0] START_X       = DEF_START_X,
  parameter logic [COORD_W-1:0] START_Y       = DEF_START_Y,
  parameter int unsigned        TIMEOUT_TICKS = 244000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BtnU_pulse,
  input  logic               BtnD_pulse,
  input  logic               BtnL_pulse,
  input  logic               BtnR_pulse,
  input  logic               BtnC_pulse,
  input  logic               move_ready,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               picking_to,
  output logic [COORD_W-1:0] from_x,
  output logic [COORD_W-1:0] from_y,
  output logic [COORD_W-1:0] to_x,
  output logic [COORD_W-1:0] to_y,
  output logic               move_valid,
  output logic               timeout,
  output state_t             dbg_state
);

  // Handshake: a move transfers on the first CLK edge where move_valid and
  // move_ready are both 1; until then move_valid, from and to hold steady.

  state_t             state_q, state_d;
  coord_t             from_q, from_d;
  coord_t             to_q, to_d;
  logic               move_valid_q, move_valid_d;
  logic               picking_to_q, picking_to_d;
  logic [COORD_W-1:0] cur_x, cur_y;
  coord_t             cursor;
  logic               axis_en;

  assign cursor  = '{x: cur_x, y: cur_y};
  assign axis_en = (state_q == PICK_FROM || state_q == PICK_TO) && !BtnC_pulse;

  cursor_axis #(.WRAP(WRAP), .START(START_X)) u_axis_x (
    .clk(CLK), .rst_n(RESET), .en(axis_en),
    .inc(BtnR_pulse), .dec(BtnL_pulse), .value(cur_x)
  );

  cursor_axis #(.WRAP(WRAP), .START(START_Y)) u_axis_y (
    .clk(CLK), .rst_n(RESET), .en(axis_en),
    .inc(BtnU_pulse), .dec(BtnD_pulse), .value(cur_y)
  );

`ifdef MOVE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             any_pulse;
  assign any_pulse = |{BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse};
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_TICKS;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= PICK_FROM;
      from_q       <= '0;
      to_q         <= '0;
      move_valid_q <= 1'b0;
      picking_to_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      from_q       <= from_d;
      to_q         <= to_d;
      move_valid_q <= move_valid_d;
      picking_to_q <= picking_to_d;
    end
  end

`ifdef MOVE_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    from_d       = from_q;
    to_d         = to_q;
    move_valid_d = move_valid_q;
    picking_to_d = picking_to_q;
`ifdef MOVE_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      PICK_FROM: begin
        if (BtnC_pulse) begin
          from_d       = cursor;
          picking_to_d = 1'b1;
          state_d      = PICK_TO;
        end
`ifdef MOVE_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      PICK_TO: begin
        if (BtnC_pulse) begin
          if (cursor == from_q) begin
            picking_to_d = 1'b0;
            state_d      = PICK_FROM;
          end else begin
            to_d         = cursor;
            move_valid_d = 1'b1;
            state_d      = SEND;
          end
        end
`ifdef MOVE_TIMEOUT_EN
        // A pulse in the terminal cycle wins over the abandon.
        if (any_pulse) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
          cnt_d        = '0;
          timeout_d    = 1'b1;
          picking_to_d = 1'b0;
          state_d      = PICK_FROM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (move_ready) begin
          move_valid_d = 1'b0;
          picking_to_d = 1'b0;
          state_d      = PICK_FROM;
        end
      end
      default: begin
        move_valid_d = 1'b0;
        picking_to_d = 1'b0;
        state_d      = PICK_FROM;
      end
    endcase
  end

  always_comb begin
    cursor_x   = cur_x;
    cursor_y   = cur_y;
    picking_to = picking_to_q;
    from_x     = from_q.x;
    from_y     = from_q.y;
    to_x       = to_q.x;
    to_y       = to_q.y;
    move_valid = move_valid_q;
    dbg_state  = state_q;
`ifdef MOVE_TIMEOUT_EN
    timeout    = timeout_q;
`else
    timeout    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_move_select.sv
// Directed bench for move_select: a wrapping and a saturating instance share stimulus.
module tb_move_select;

  logic clk = 1'b0;
  logic rst_n;
  logic bu, bd, bl, br, bc, mready;

  logic [2:0] cx, cy, fx, fy, tx, ty;
  logic       pt, mv, tmo;
  logic [1:0] st;
  logic [2:0] s_cx, s_cy, s_fx, s_fy, s_tx, s_ty;
  logic       s_pt, s_mv, s_tmo;
  logic [1:0] s_st;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  move_select #(.WRAP(1'b1), .TIMEOUT_TICKS(16)) dut (
    .CLK(clk), .RESET(rst_n),
    .BtnU_pulse(bu), .BtnD_pulse(bd), .BtnL_pulse(bl), .BtnR_pulse(br), .BtnC_pulse(bc),
    .move_ready(mready),
    .cursor_x(cx), .cursor_y(cy), .picking_to(pt),
    .from_x(fx), .from_y(fy), .to_x(tx), .to_y(ty),
    .move_valid(mv), .timeout(tmo), .dbg_state(st)
  );

  move_select #(.WRAP(1'b0), .TIMEOUT_TICKS(16)) dut_sat (
    .CLK(clk), .RESET(rst_n),
    .BtnU_pulse(bu), .BtnD_pulse(bd), .BtnL_pulse(bl), .BtnR_pulse(br), .BtnC_pulse(bc),
    .move_ready(mready),
    .cursor_x(s_cx), .cursor_y(s_cy), .picking_to(s_pt),
    .from_x(s_fx), .from_y(s_fy), .to_x(s_tx), .to_y(s_ty),
    .move_valid(s_mv), .timeout(s_tmo), .dbg_state(s_st)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge: drives one pulse cycle, returns at the following negedge.
  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic c);
    bu = u; bd = d; bl = l; br = r; bc = c;
    @(negedge clk);
    bu = 0; bd = 0; bl = 0; br = 0; bc = 0;
  endtask

  task automatic chk_cur(input string tag, input logic [2:0] ex, input logic [2:0] ey);
    chk({tag, "_x"}, 32'(cx), 32'(ex));
    chk({tag, "_y"}, 32'(cy), 32'(ey));
  endtask

  task automatic chk_sat(input string tag, input logic [2:0] ex, input logic [2:0] ey);
    chk({tag, "_sat_x"}, 32'(s_cx), 32'(ex));
    chk({tag, "_sat_y"}, 32'(s_cy), 32'(ey));
  endtask

  initial begin
    rst_n = 0; bu = 0; bd = 0; bl = 0; br = 0; bc = 0; mready = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk_cur("rst_cursor", 3'd4, 3'd1);
    chk_sat("rst_cursor", 3'd4, 3'd1);
    chk("rst_mv", 32'(mv), 0);
    chk("rst_pt", 32'(pt), 0);
    chk("rst_from", 32'({fx, fy}), 0);
    chk("rst_to", 32'({tx, ty}), 0);
    chk("rst_timeout", 32'(tmo), 0);
    chk("rst_state", 32'(st), 0);
    chk("rst_sat_misc", 32'({s_mv, s_pt, s_fx, s_fy, s_tx, s_ty, s_tmo, s_st}), 0);
    rst_n = 1;
    @(negedge clk);

    // Pawn move e2 -> e4-ish: (4,1) -> (4,3)
    press(1, 0, 0, 0, 0); chk_cur("up", 3'd4, 3'd2);
    press(0, 1, 0, 0, 0); chk_cur("down", 3'd4, 3'd1);
    press(0, 0, 0, 0, 1);
    chk("pick_pt", 32'(pt), 1);
    chk("pick_state", 32'(st), 1);
    chk("pick_from", 32'({fx, fy}), 32'({3'd4, 3'd1}));
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0); chk_cur("to_cursor", 3'd4, 3'd3);
    chk("pre_send_mv", 32'(mv), 0);
    press(0, 0, 0, 0, 1);
    chk("send_mv", 32'(mv), 1);
    chk("send_state", 32'(st), 2);
    chk("send_to", 32'({tx, ty}), 32'({3'd4, 3'd3}));
    chk("send_sat_mv", 32'(s_mv), 1);

    // Stall with move_ready=0; pulses are ignored
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    press(1, 0, 1, 0, 0);
    press(0, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    chk("stall_mv", 32'(mv), 1);
    chk("stall_pt", 32'(pt), 1);
    chk("stall_from", 32'({fx, fy}), 32'({3'd4, 3'd1}));
    chk("stall_to", 32'({tx, ty}), 32'({3'd4, 3'd3}));
    chk_cur("stall_cursor", 3'd4, 3'd3);

    mready = 1;
    @(negedge clk);
    mready = 0;
    chk("xfer_mv", 32'(mv), 0);
    chk("xfer_state", 32'(st), 0);
    chk("xfer_pt", 32'(pt), 0);
    chk_cur("xfer_cursor", 3'd4, 3'd3);

    // Edges: drive both instances to (7,0)
    press(0, 0, 0, 1, 0); press(0, 0, 0, 1, 0); press(0, 0, 0, 1, 0);
    press(0, 1, 0, 0, 0); press(0, 1, 0, 0, 0); press(0, 1, 0, 0, 0);
    chk_cur("corner", 3'd7, 3'd0);
    chk_sat("corner", 3'd7, 3'd0);
    press(0, 0, 0, 1, 0);
    chk_cur("wrap_r", 3'd0, 3'd0);
    chk_sat("clamp_r", 3'd7, 3'd0);
    press(0, 1, 0, 0, 0);
    chk_cur("wrap_d", 3'd0, 3'd7);
    chk_sat("clamp_d", 3'd7, 3'd0);
    press(1, 1, 0, 0, 0);
    chk_cur("u_and_d", 3'd0, 3'd7);
    chk_sat("u_and_d", 3'd7, 3'd0);

    // Diagonal from (2,2)
    press(0, 0, 0, 1, 0); press(0, 0, 0, 1, 0);
    press(1, 0, 0, 0, 0); press(1, 0, 0, 0, 0); press(1, 0, 0, 0, 0);
    chk_cur("at_2_2", 3'd2, 3'd2);
    press(1, 0, 0, 1, 0);
    chk_cur("diag", 3'd3, 3'd3);
    press(0, 0, 1, 1, 0);
    chk_cur("l_and_r", 3'd3, 3'd3);

    // Cancel at (5,5)
    press(0, 0, 0, 1, 0); press(0, 0, 0, 1, 0);
    press(1, 0, 0, 0, 0); press(1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    chk("cancel_pick_pt", 32'(pt), 1);
    chk("cancel_from", 32'({fx, fy}), 32'({3'd5, 3'd5}));
    press(0, 0, 0, 0, 1);
    chk("cancel_pt", 32'(pt), 0);
    chk("cancel_mv", 32'(mv), 0);
    chk("cancel_state", 32'(st), 0);
    chk("cancel_sat_mv", 32'(s_mv), 0);

    // Centre priority at (1,1)
    repeat (4) press(0, 0, 1, 0, 0);
    repeat (4) press(0, 1, 0, 0, 0);
    chk_cur("at_1_1", 3'd1, 3'd1);
    press(0, 0, 0, 1, 1);
    chk("prio_from", 32'({fx, fy}), 32'({3'd1, 3'd1}));
    chk_cur("prio_cursor", 3'd1, 3'd1);
    chk("prio_pt", 32'(pt), 1);
    press(0, 0, 0, 0, 1);
    chk("prio_cancel_state", 32'(st), 0);

    // Reset while a move is presented
    press(0, 0, 0, 0, 1);
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    chk("rs_send_mv", 32'(mv), 1);
    chk("rs_send_to", 32'({tx, ty}), 32'({3'd2, 3'd1}));
    rst_n = 0;
    @(negedge clk);
    chk("rs_mv", 32'(mv), 0);
    chk_cur("rs_cursor", 3'd4, 3'd1);
    chk("rs_state", 32'(st), 0);
    chk("rs_from", 32'({fx, fy}), 0);
    rst_n = 1;
    @(negedge clk);

`ifdef MOVE_TIMEOUT_EN
    // Abandon after 16 idle cycles in PICK_TO
    press(0, 0, 0, 0, 1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("tmo_idle", 32'(tmo), 0);
    end
    @(negedge clk);
    chk("tmo_pulse", 32'(tmo), 1);
    chk("tmo_state", 32'(st), 0);
    chk("tmo_pt", 32'(pt), 0);
    @(negedge clk);
    chk("tmo_one_cycle", 32'(tmo), 0);

    // A pulse at cycle 10 restarts the count
    press(0, 0, 0, 0, 1);
    repeat (9) @(negedge clk);
    press(0, 0, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("tmo_restart_idle", 32'(tmo), 0);
    end
    chk("tmo_restart_state", 32'(st), 1);
    @(negedge clk);
    chk("tmo_restart_pulse", 32'(tmo), 1);
    chk("tmo_restart_back", 32'(st), 0);
`else
    // Without the timeout PICK_TO waits indefinitely
    press(0, 0, 0, 0, 1);
    repeat (40) @(negedge clk);
    chk("no_tmo_pulse", 32'(tmo), 0);
    chk("no_tmo_state", 32'(st), 1);
    chk("no_tmo_pt", 32'(pt), 1);
    press(0, 0, 0, 0, 1);
    chk("no_tmo_cancel", 32'(st), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
